vproc_vrot_unit: RTL and testbench

- Execution stage downstream of custom-instruction dispatch. Consumes one custom_instr_signals descriptor plus the source vector register, streamed in OP_W-bit chunks.
- Rotates the first vector_length bytes of the register down by rotation_amount bytes, taken modulo vector_length.
- Streams the result back in chunks toward vector register writeback.
- Bytes at or above vector_length pass through unchanged (tail undisturbed).

---
 rtl/vproc_custom.sv | 25 ++
 rtl/vproc_vrot_byte_rotator.sv | 34 +++
 rtl/vproc_vrot_unit.sv | 148 ++++++++++++++
 tb/tb_vproc_vrot_unit.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/vproc_custom.sv
// Shared types and constants for the custom-instruction execution units.
// Holds the dispatch descriptor struct and the vector-rotate unit's state encoding.
package vproc_custom;

    localparam int unsigned ROT_AMOUNT_BIT = 8;
    localparam int unsigned VROT_VREG_W    = 128;
    localparam int unsigned VROT_OP_W      = 32;
    localparam int unsigned VROT_VL_BIT    = $clog2(VROT_VREG_W);
    localparam int unsigned VROT_CHUNKS    = VROT_VREG_W / VROT_OP_W;

    typedef struct packed {
        logic [ROT_AMOUNT_BIT-1:0] rotation_amount;
        logic [ROT_AMOUNT_BIT-1:0] temp_rotation_amount;
        logic [VROT_VL_BIT-1:0]    vector_length;
    } custom_instr_signals;

    typedef enum logic [2:0] {
        IDLE,
        NORM,
        LOAD,
        ROT,
        DRAIN
    } vrot_state_e;

endpackage

// File: rtl/vproc_vrot_byte_rotator.sv
// Combinational byte permutation: rotates the first vl bytes down by r, leaves the tail intact.
// Expects r < vl (already reduced), so the wrap needs only one conditional subtract.
module vproc_vrot_byte_rotator
    import vproc_custom::*;
#(
    parameter int unsigned VREG_W = VROT_VREG_W
) (
    input  logic [VREG_W-1:0]         buf_i,
    input  logic [ROT_AMOUNT_BIT-1:0] rot_i,
    input  logic [$clog2(VREG_W)-1:0] vl_i,
    output logic [VREG_W-1:0]         res_o
);

    localparam int NBYTES = int'(VREG_W / 8);

    always_comb begin
        int vlc;
        int idx;
        res_o = buf_i;
        idx   = 0;
        vlc   = (int'(vl_i) > NBYTES) ? NBYTES : int'(vl_i);
        for (int i = 0; i < NBYTES; i++) begin
            idx = i + int'(rot_i);
            if (idx >= vlc) begin
                idx = idx - vlc;
            end
            // Bound check only matters when r was not reduced below vl.
            if ((i < vlc) && (idx < NBYTES)) begin
                res_o[i*8 +: 8] = buf_i[idx*8 +: 8];
            end
        end
    end

endmodule

// File: rtl/vproc_vrot_unit.sv
// Vector byte-rotate execution stage: accepts a descriptor, streams the source register in,
// reduces the rotation modulo vl, permutes once, then streams the result out chunk by chunk.
module vproc_vrot_unit
    import vproc_custom::*;
#(
    parameter int unsigned VREG_W = VROT_VREG_W,
    parameter int unsigned OP_W   = VROT_OP_W
) (
    input  logic                clk_i,
    input  logic                sync_rst_i,
    input  logic                op_valid_i,
    output logic                op_ready_o,
    input  custom_instr_signals op_sig_i,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic [OP_W-1:0]     in_data_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [OP_W-1:0]     out_data_o,
    output logic                out_last_o,
    output logic                busy_o
);

    localparam int unsigned CHUNKS = VREG_W / OP_W;
    localparam int unsigned CNT_W  = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam int unsigned VL_W   = $clog2(VREG_W);
    localparam int unsigned NBYTES = VREG_W / 8;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CHUNKS - 1);

    vrot_state_e               state_q;
    logic [CNT_W-1:0]          cnt_q;
    logic [ROT_AMOUNT_BIT-1:0] r_q;
    logic [VL_W-1:0]           vl_q;
    logic [VREG_W-1:0]         buf_q;
    logic [VREG_W-1:0]         res_q;
    logic                      op_ready_q;
    logic                      in_ready_q;
    logic                      out_valid_q;
    logic                      out_last_q;
    logic [OP_W-1:0]           out_data_q;
    logic                      busy_q;

    logic [VL_W-1:0]           vlIn;
    logic [ROT_AMOUNT_BIT-1:0] vlExt;
    logic [CNT_W-1:0]          cntNext_d;
    logic [VREG_W-1:0]         rotRes;

    // Clamp at latch time so NORM reduces r below the effective length, keeping r < vl in ROT.
    assign vlIn      = (int'(op_sig_i.vector_length) > int'(NBYTES)) ? VL_W'(NBYTES)
                                                                     : VL_W'(op_sig_i.vector_length);
    assign vlExt     = ROT_AMOUNT_BIT'(vl_q);
    assign cntNext_d = cnt_q + 1'b1;

    vproc_vrot_byte_rotator #(
        .VREG_W (VREG_W)
    ) u_rotator (
        .buf_i (buf_q),
        .rot_i (r_q),
        .vl_i  (vl_q),
        .res_o (rotRes)
    );

    always_ff @(posedge clk_i) begin
        if (sync_rst_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            r_q         <= '0;
            vl_q        <= '0;
            op_ready_q  <= 1'b1;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (op_valid_i) begin
                        r_q        <= op_sig_i.rotation_amount;
                        vl_q       <= vlIn;
                        op_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= NORM;
                    end
                end
                NORM: begin
                    if (vl_q == '0) begin
                        r_q        <= '0;
                        in_ready_q <= 1'b1;
                        state_q    <= LOAD;
                    end else if (r_q >= vlExt) begin
                        r_q <= r_q - vlExt;
                    end else begin
                        in_ready_q <= 1'b1;
                        state_q    <= LOAD;
                    end
                end
                LOAD: begin
                    if (in_valid_i) begin
                        buf_q[cnt_q*OP_W +: OP_W] <= in_data_i;
                        if (cnt_q == LAST_CNT) begin
                            cnt_q      <= '0;
                            in_ready_q <= 1'b0;
                            state_q    <= ROT;
                        end else begin
                            cnt_q <= cntNext_d;
                        end
                    end
                end
                ROT: begin
                    res_q       <= rotRes;
                    out_data_q  <= rotRes[OP_W-1:0];
                    out_valid_q <= 1'b1;
                    out_last_q  <= (CHUNKS == 1);
                    state_q     <= DRAIN;
                end
                DRAIN: begin
                    if (out_ready_i) begin
                        if (cnt_q == LAST_CNT) begin
                            cnt_q       <= '0;
                            out_valid_q <= 1'b0;
                            out_last_q  <= 1'b0;
                            out_data_q  <= '0;
                            busy_q      <= 1'b0;
                            op_ready_q  <= 1'b1;
                            state_q     <= IDLE;
                        end else begin
                            cnt_q      <= cntNext_d;
                            out_data_q <= res_q[cntNext_d*OP_W +: OP_W];
                            out_last_q <= (cntNext_d == LAST_CNT);
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign op_ready_o  = op_ready_q;
    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign out_last_o  = out_last_q;
    assign out_data_o  = out_data_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_vproc_vrot_unit.sv
// Directed scoreboard bench for vproc_vrot_unit: a reference model queues the expected
// result chunks at op issue, and they are popped as the unit streams its output.
module tb_vproc_vrot_unit;
    import vproc_custom::*;

    localparam int VREG_W  = 128;
    localparam int OP_W    = 32;
    localparam int CHUNKS  = VREG_W / OP_W;
    localparam int NBYTES  = VREG_W / 8;
    localparam int TIMEOUT = 200;

    typedef struct {
        logic [OP_W-1:0] data;
        logic            last;
    } exp_t;

    logic                clk_i = 1'b0;
    logic                sync_rst_i;
    logic                op_valid_i;
    logic                op_ready_o;
    custom_instr_signals op_sig_i;
    logic                in_valid_i;
    logic                in_ready_o;
    logic [OP_W-1:0]     in_data_i;
    logic                out_valid_o;
    logic                out_ready_i;
    logic [OP_W-1:0]     out_data_o;
    logic                out_last_o;
    logic                busy_o;

    exp_t              expQ[$];
    int                total = 0;
    int                bad   = 0;
    logic [VREG_W-1:0] src;

    always #5 clk_i = ~clk_i;

    vproc_vrot_unit #(
        .VREG_W (VREG_W),
        .OP_W   (OP_W)
    ) dut (
        .clk_i       (clk_i),
        .sync_rst_i  (sync_rst_i),
        .op_valid_i  (op_valid_i),
        .op_ready_o  (op_ready_o),
        .op_sig_i    (op_sig_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_data_i   (in_data_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_data_o  (out_data_o),
        .out_last_o  (out_last_o),
        .busy_o      (busy_o)
    );

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [OP_W-1:0] obs, input logic [OP_W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
        end
    endtask

    function automatic logic [VREG_W-1:0] model(input logic [VREG_W-1:0] s, input int vl, input int r);
        int vlc;
        int re;
        vlc   = (vl > NBYTES) ? NBYTES : vl;
        re    = (vlc == 0) ? 0 : (r % vlc);
        model = s;
        for (int i = 0; i < vlc; i++) begin
            model[i*8 +: 8] = s[((i + re) % vlc)*8 +: 8];
        end
    endfunction

    task automatic applyStimulus(input int vl, input int r, input int gaps, input string tag);
        logic [VREG_W-1:0] res;
        int n;
        int vlc;
        int normExp;
        exp_t e;
        res = model(src, vl, r);
        for (int k = 0; k < CHUNKS; k++) begin
            e.data = res[k*OP_W +: OP_W];
            e.last = (k == CHUNKS - 1);
            expQ.push_back(e);
        end
        vlc     = (vl > NBYTES) ? NBYTES : vl;
        normExp = (vlc == 0) ? 1 : (r / vlc + 1);

        op_sig_i.rotation_amount      = 8'(r);
        op_sig_i.vector_length        = 7'(vl);
        op_sig_i.temp_rotation_amount = 8'($urandom);
        op_valid_i = 1'b1;
        n = 0;
        while (!op_ready_o && n < TIMEOUT) begin
            tick();
            n++;
        end
        tick();
        op_valid_i = 1'b0;

        n = 0;
        while (!in_ready_o && n < TIMEOUT) begin
            tick();
            n++;
        end
        checkOutput({tag, " norm_cycles"}, 32'(n), 32'(normExp));

        for (int k = 0; k < CHUNKS; k++) begin
            repeat (gaps) begin
                in_valid_i = 1'b0;
                tick();
            end
            in_valid_i = 1'b1;
            in_data_i  = src[k*OP_W +: OP_W];
            tick();
        end
        in_valid_i = 1'b0;
    endtask

    task automatic drainOutput(input int nChunks, input int holdCycles, input string tag);
        int n;
        exp_t e;
        n = 0;
        while (!out_valid_o && n < TIMEOUT) begin
            tick();
            n++;
        end
        if (n >= TIMEOUT) begin
            checkOutput({tag, " out_valid_timeout"}, 32'(out_valid_o), 32'd1);
            return;
        end
        if (holdCycles > 0 && expQ.size() > 0) begin
            for (int h = 0; h < holdCycles; h++) begin
                tick();
                checkOutput({tag, " hold_data"}, out_data_o, expQ[0].data);
                checkOutput({tag, " hold_valid"}, 32'(out_valid_o), 32'd1);
                checkOutput({tag, " hold_op_ready"}, 32'(op_ready_o), 32'd0);
            end
        end
        out_ready_i = 1'b1;
        for (int c = 0; c < nChunks; c++) begin
            n = 0;
            while (!out_valid_o && n < TIMEOUT) begin
                tick();
                n++;
            end
            if (expQ.size() == 0) begin
                checkOutput({tag, " queue_empty"}, 32'd0, 32'd1);
                break;
            end
            e = expQ.pop_front();
            checkOutput($sformatf("%s chunk%0d_data", tag, c), out_data_o, e.data);
            checkOutput($sformatf("%s chunk%0d_last", tag, c), 32'(out_last_o), 32'(e.last));
            checkOutput($sformatf("%s chunk%0d_op_ready", tag, c), 32'(op_ready_o), 32'd0);
            tick();
        end
        out_ready_i = 1'b0;
        if (nChunks == CHUNKS) begin
            checkOutput({tag, " end_op_ready"}, 32'(op_ready_o), 32'd1);
            checkOutput({tag, " end_busy"}, 32'(busy_o), 32'd0);
            checkOutput({tag, " end_out_valid"}, 32'(out_valid_o), 32'd0);
        end
    endtask

    initial begin
        sync_rst_i  = 1'b1;
        op_valid_i  = 1'b0;
        op_sig_i    = '0;
        in_valid_i  = 1'b0;
        in_data_i   = '0;
        out_ready_i = 1'b0;
        for (int b = 0; b < NBYTES; b++) begin
            src[b*8 +: 8] = 8'(b);
        end
        repeat (3) tick();
        sync_rst_i = 1'b0;

        checkOutput("reset out_valid", 32'(out_valid_o), 32'd0);
        checkOutput("reset out_last", 32'(out_last_o), 32'd0);
        checkOutput("reset out_data", out_data_o, 32'd0);
        checkOutput("reset in_ready", 32'(in_ready_o), 32'd0);
        checkOutput("reset busy", 32'(busy_o), 32'd0);
        checkOutput("reset op_ready", 32'(op_ready_o), 32'd1);

        $display("[TB] scenario 1: vl=16 r=3");
        applyStimulus(16, 3, 0, "s1");
        drainOutput(CHUNKS, 0, "s1");

        $display("[TB] scenario 2: vl=8 r=10");
        applyStimulus(8, 10, 0, "s2");
        drainOutput(CHUNKS, 0, "s2");

        $display("[TB] scenario 3: vl=0 r=5");
        applyStimulus(0, 5, 0, "s3");
        drainOutput(CHUNKS, 0, "s3");

        $display("[TB] scenario 4: vl=16 r=0 with output backpressure");
        applyStimulus(16, 0, 0, "s4");
        drainOutput(CHUNKS, 5, "s4");

        $display("[TB] scenario 5: vl=16 r=32 with input gaps");
        applyStimulus(16, 32, 2, "s5");
        drainOutput(CHUNKS, 0, "s5");

        $display("[TB] scenario 6: reset during drain");
        applyStimulus(16, 1, 0, "s6a");
        drainOutput(2, 0, "s6a");
        sync_rst_i = 1'b1;
        tick();
        sync_rst_i = 1'b0;
        expQ.delete();
        checkOutput("s6 rst out_valid", 32'(out_valid_o), 32'd0);
        checkOutput("s6 rst busy", 32'(busy_o), 32'd0);
        checkOutput("s6 rst op_ready", 32'(op_ready_o), 32'd1);
        applyStimulus(16, 1, 0, "s6b");
        drainOutput(CHUNKS, 0, "s6b");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
